exu_operand_buffer: RTL and testbench
=====================================

Name: exu_operand_buffer

Overview:
- Parametrised operand-capture stage for the execute unit; generalises the two-source RAW forward skid buffer to NSRC sources of XLEN bits.
- Sits between the ID/EX pipeline register and the ALU/LSU request logic, and drives EX ready_go.
- Per source, picks live forward data, a captured forward, or the regfile read value.
- Holds one-shot forwards across downstream stalls, supports flush, and counts hazard-stall cycles.

Parameters:
- XLEN, 64, operand width in bits.
- NSRC, 2, number of source operands.
- CNTW, 32, width of the saturating stall counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  EX stage holds a valid instruction.
- in_ready  out  1  EX can accept the next instruction.
- src_hazard  in  NSRC  bit i=1: source i has an unresolved RAW hazard.
- src_rdata  in  NSRC*XLEN  regfile read data; source i at [i*XLEN +: XLEN].
- fwd_valid  in  NSRC  one-cycle forward strobe per source.
- fwd_data  in  NSRC*XLEN  forward data, same packing as src_rdata.
- out_valid  out  1  all operands resolved; offer to downstream.
- out_ready  in  1  downstream (LSU/allow_in) accepts.
- op_data  out  NSRC*XLEN  selected operand values.
- op_resolved  out  NSRC  per-source resolved flag.
- flush  in  1  pipeline flush; discards captured state.
- stall_cnt  out  CNTW  cycles with in_valid=1 and some source unresolved; saturates.

Behaviour:
- State per source i: cap_v[i] (1 bit) and cap_d[i] (XLEN bits). Global: stall_cnt.
- Reset (rst=0, async): cap_v=0, cap_d=0, stall_cnt=0.
- During reset, outputs follow the combinational equations with cap_v=0.
- fire = out_valid & out_ready.
- Operand select, combinational, priority order:
  - fwd_valid[i] -> fwd_data[i];
  - else cap_v[i] -> cap_d[i];
  - else src_rdata[i].
- op_resolved[i] = ~src_hazard[i] | fwd_valid[i] | cap_v[i].
- all_res = AND of op_resolved over all sources.
- out_valid = in_valid & all_res & ~flush.
- in_ready = ~in_valid | (all_res & out_ready & ~flush).
- Capture rule, per source, evaluated at the clock edge:
  - If flush: cap_v[i] <= 0.
  - Else if fire: cap_v[i] <= 0. The buffer is consumed; a fwd_valid in the same cycle is used combinationally and not stored.
  - Else if in_valid & fwd_valid[i]: cap_v[i] <= 1 and cap_d[i] <= fwd_data[i]. A newer forward overwrites an already-captured value.
  - Else: hold.
- cap_d is written only on a capture; it is never cleared except by reset.
- Sources are independent. Source 0 may be captured while source 1 is still waiting.
- A forward arriving with in_valid=0 is ignored.
- stall_cnt increments by 1 each cycle with in_valid & ~all_res & ~flush. It saturates at 2^CNTW-1 and never wraps.
- Downstream back-pressure (all_res=1, out_ready=0) does not count as a stall.
- flush and fire in the same cycle: flush wins; out_valid=0, so fire cannot occur.
- Reset asserted mid-stall: all captures lost immediately; the first cycle after release behaves as a fresh instruction.
- Latency: zero cycles from resolution to out_valid. A forward becomes usable in the cycle it is strobed, and stays usable from cap_d on every following cycle.

Test Plan:
- NSRC=2, no hazards, in_valid=1, out_ready=1, src_rdata={0x22,0x11} -> out_valid=1 same cycle, op_data={0x22,0x11}, stall_cnt stays 0.
- Source 0 hazard; fwd_valid[0] pulses with 0xDEAD while out_ready=0 for 3 cycles -> op_data[0]=0xDEAD on all cycles. cap_v[0]=1 until out_ready=1 fires, then 0.
- Both hazards; fwd 0xA on src0 in cycle 1, fwd 0xB on src1 in cycle 3 -> out_valid only from cycle 3, op_data={0xB,0xA}, stall_cnt=2.
- Captured 0x5, then a second fwd_valid[0]=0x6 while still stalled -> buffer updated, op_data[0]=0x6 on fire.
- Source captured, then flush=1 -> out_valid=0 that cycle, cap_v=0 next cycle. The new instruction with hazard waits (out_valid=0).
- CNTW=4, hold a hazard for 20 cycles -> stall_cnt stops at 15. Assert rst=0 mid-stall -> stall_cnt=0 and cap_v=0 immediately, asynchronously.

Source files
------------

// File: rtl/exu_operand_buffer.sv
// exu_operand_buffer: per-source RAW forward capture with flush and saturating stall counter
module exu_operand_buffer #(
  parameter int XLEN = 64,
  parameter int NSRC = 2,
  parameter int CNTW = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NSRC-1:0]      src_hazard,
  input  logic [NSRC*XLEN-1:0] src_rdata,
  input  logic [NSRC-1:0]      fwd_valid,
  input  logic [NSRC*XLEN-1:0] fwd_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NSRC*XLEN-1:0] op_data,
  output logic [NSRC-1:0]      op_resolved,
  input  logic                 flush,
  output logic [CNTW-1:0]      stall_cnt
);
  logic [NSRC-1:0] cap_v;
  logic            all_res;
  logic            fire;
  assign op_resolved = ~src_hazard | fwd_valid | cap_v;
  assign all_res     = &op_resolved;
  assign out_valid   = in_valid & all_res & ~flush;
  assign in_ready    = ~in_valid | (all_res & out_ready & ~flush);
  assign fire        = out_valid & out_ready;
  for (genvar i = 0; i < NSRC; i++) begin : g_src
    logic            v;
    logic [XLEN-1:0] d;
    // a forward seen in the firing cycle is consumed live and never stored
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        v <= 1'b0;
        d <= '0;
      end else if (flush || fire) v <= 1'b0;
      else if (in_valid && fwd_valid[i]) begin
        v <= 1'b1;
        d <= fwd_data[i*XLEN +: XLEN];
      end
    assign cap_v[i] = v;
    assign op_data[i*XLEN +: XLEN] = fwd_valid[i] ? fwd_data[i*XLEN +: XLEN] :
                                     v            ? d : src_rdata[i*XLEN +: XLEN];
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) stall_cnt <= '0;
    else if (in_valid && !all_res && !flush && !(&stall_cnt)) stall_cnt <= stall_cnt + CNTW'(1);
endmodule

// File: tb/tb_exu_operand_buffer.sv
// tb_exu_operand_buffer: directed vector table, corner sequences and randomized run against a reference model
module tb_exu_operand_buffer;
  localparam int XLEN = 64;
  localparam int NSRC = 2;
  localparam int CNTW = 4;
  localparam int CMAX = (1 << CNTW) - 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [NSRC-1:0]      src_hazard = '0;
  logic [NSRC*XLEN-1:0] src_rdata = '0;
  logic [NSRC-1:0]      fwd_valid = '0;
  logic [NSRC*XLEN-1:0] fwd_data = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [NSRC*XLEN-1:0] op_data;
  logic [NSRC-1:0]      op_resolved;
  logic                 flush = 1'b0;
  logic [CNTW-1:0]      stall_cnt;

  always #5 clk = ~clk;

  exu_operand_buffer #(.XLEN(XLEN), .NSRC(NSRC), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .src_hazard(src_hazard), .src_rdata(src_rdata), .fwd_valid(fwd_valid),
    .fwd_data(fwd_data), .out_valid(out_valid), .out_ready(out_ready),
    .op_data(op_data), .op_resolved(op_resolved), .flush(flush), .stall_cnt(stall_cnt)
  );

  int total = 0;
  int bad = 0;

  // reference: a per-source "pending forwarded value" slot and a stall tally
  logic            m_has[NSRC];
  logic [XLEN-1:0] m_val[NSRC];
  int              m_cnt;
  logic            m_allr;
  logic            m_ov;

  task automatic chk(input string n, input logic [NSRC*XLEN-1:0] a, input logic [NSRC*XLEN-1:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic model_clear;
    for (int i = 0; i < NSRC; i++) begin
      m_has[i] = 1'b0;
      m_val[i] = '0;
    end
    m_cnt = 0;
  endtask

  task automatic model_check;
    logic [NSRC*XLEN-1:0] ed;
    logic [NSRC-1:0]      er;
    for (int i = 0; i < NSRC; i++) begin
      ed[i*XLEN +: XLEN] = fwd_valid[i] ? fwd_data[i*XLEN +: XLEN] :
                           m_has[i] ? m_val[i] : src_rdata[i*XLEN +: XLEN];
      er[i] = !src_hazard[i] || fwd_valid[i] || m_has[i];
    end
    m_allr = &er;
    m_ov = in_valid && m_allr && !flush;
    chk("m_out_valid", out_valid, m_ov);
    chk("m_in_ready", in_ready, !in_valid || (m_allr && out_ready && !flush));
    chk("m_op_data", op_data, ed);
    chk("m_op_resolved", op_resolved, er);
    chk("m_stall_cnt", stall_cnt, m_cnt);
  endtask

  task automatic model_step;
    bit fire;
    fire = m_ov && out_ready;
    for (int i = 0; i < NSRC; i++)
      if (flush || fire) m_has[i] = 1'b0;
      else if (in_valid && fwd_valid[i]) begin
        m_has[i] = 1'b1;
        m_val[i] = fwd_data[i*XLEN +: XLEN];
      end
    if (in_valid && !m_allr && !flush && m_cnt < CMAX) m_cnt++;
  endtask

  task automatic cyc;
    #2;
    model_check();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    #1;
    model_clear();
    chk("rst_cnt", stall_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  typedef struct {
    logic            iv;
    logic [1:0]      haz;
    logic [1:0]      fv;
    logic [XLEN-1:0] fd0;
    logic [XLEN-1:0] fd1;
    logic            ordy;
    logic            fl;
    logic            e_ov;
    logic            e_ir;
    logic [XLEN-1:0] e_d0;
    logic [XLEN-1:0] e_d1;
    logic [CNTW-1:0] e_cnt;
  } vec_t;

  vec_t vt[17];

  initial begin
    vt[0]  = '{1, 2'b00, 2'b00, 64'h0,    64'h0, 1, 0, 1, 1, 64'h11,   64'h22, 4'd0};
    vt[1]  = '{1, 2'b01, 2'b01, 64'hDEAD, 64'h0, 0, 0, 1, 0, 64'hDEAD, 64'h22, 4'd0};
    vt[2]  = '{1, 2'b01, 2'b00, 64'h0,    64'h0, 0, 0, 1, 0, 64'hDEAD, 64'h22, 4'd0};
    vt[3]  = '{1, 2'b01, 2'b00, 64'h0,    64'h0, 0, 0, 1, 0, 64'hDEAD, 64'h22, 4'd0};
    vt[4]  = '{1, 2'b01, 2'b00, 64'h0,    64'h0, 1, 0, 1, 1, 64'hDEAD, 64'h22, 4'd0};
    vt[5]  = '{0, 2'b01, 2'b00, 64'h0,    64'h0, 1, 0, 0, 1, 64'h11,   64'h22, 4'd0};
    vt[6]  = '{1, 2'b11, 2'b01, 64'hA,    64'h0, 1, 0, 0, 0, 64'hA,    64'h22, 4'd0};
    vt[7]  = '{1, 2'b11, 2'b00, 64'h0,    64'h0, 1, 0, 0, 0, 64'hA,    64'h22, 4'd1};
    vt[8]  = '{1, 2'b11, 2'b10, 64'h0,    64'hB, 1, 0, 1, 1, 64'hA,    64'hB,  4'd2};
    vt[9]  = '{1, 2'b01, 2'b01, 64'h5,    64'h0, 0, 0, 1, 0, 64'h5,    64'h22, 4'd2};
    vt[10] = '{1, 2'b01, 2'b01, 64'h6,    64'h0, 0, 0, 1, 0, 64'h6,    64'h22, 4'd2};
    vt[11] = '{1, 2'b01, 2'b00, 64'h0,    64'h0, 1, 0, 1, 1, 64'h6,    64'h22, 4'd2};
    vt[12] = '{1, 2'b11, 2'b01, 64'h7,    64'h0, 1, 0, 0, 0, 64'h7,    64'h22, 4'd2};
    vt[13] = '{1, 2'b11, 2'b00, 64'h0,    64'h0, 1, 1, 0, 0, 64'h7,    64'h22, 4'd3};
    vt[14] = '{1, 2'b01, 2'b00, 64'h0,    64'h0, 1, 0, 0, 0, 64'h11,   64'h22, 4'd3};
    vt[15] = '{0, 2'b01, 2'b01, 64'h99,   64'h0, 1, 0, 0, 1, 64'h99,   64'h22, 4'd4};
    vt[16] = '{1, 2'b01, 2'b00, 64'h0,    64'h0, 1, 0, 0, 0, 64'h11,   64'h22, 4'd4};

    model_clear();
    in_valid = 1'b1;
    src_hazard = 2'b11;
    #3;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_resolved", op_resolved, 2'b00);
    chk("reset_cnt", stall_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int k = 0; k < 17; k++) begin
      in_valid   = vt[k].iv;
      src_hazard = vt[k].haz;
      src_rdata  = {64'h22, 64'h11};
      fwd_valid  = vt[k].fv;
      fwd_data   = {vt[k].fd1, vt[k].fd0};
      out_ready  = vt[k].ordy;
      flush      = vt[k].fl;
      #2;
      model_check();
      chk($sformatf("v%0d_out_valid", k), out_valid, vt[k].e_ov);
      chk($sformatf("v%0d_in_ready", k), in_ready, vt[k].e_ir);
      chk($sformatf("v%0d_op0", k), op_data[XLEN-1:0], vt[k].e_d0);
      chk($sformatf("v%0d_op1", k), op_data[2*XLEN-1:XLEN], vt[k].e_d1);
      chk($sformatf("v%0d_cnt", k), stall_cnt, vt[k].e_cnt);
      model_step();
      @(posedge clk);
      #1;
    end

    do_reset();
    in_valid = 1'b1;
    src_hazard = 2'b01;
    fwd_valid = 2'b00;
    flush = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) cyc();
    #2;
    chk("saturate", stall_cnt, 4'd15);

    src_hazard = 2'b11;
    fwd_valid = 2'b01;
    fwd_data = {64'h0, 64'h55};
    cyc();
    fwd_valid = 2'b00;
    #2;
    chk("cap_held_res", op_resolved, 2'b01);
    chk("cap_held_data", op_data[XLEN-1:0], 64'h55);
    rst = 1'b0;
    #1;
    model_clear();
    chk("async_rst_cnt", stall_cnt, 0);
    chk("async_rst_res", op_resolved, 2'b00);
    chk("async_rst_ov", out_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc();

    for (int k = 0; k < 600; k++) begin
      if (k % 60 == 59) do_reset();
      in_valid   = $urandom_range(0, 3) != 0;
      src_hazard = NSRC'($urandom);
      src_rdata  = {$urandom, $urandom, $urandom, $urandom};
      fwd_valid  = ($urandom_range(0, 2) == 0) ? NSRC'($urandom) : '0;
      fwd_data   = {$urandom, $urandom, $urandom, $urandom};
      out_ready  = $urandom_range(0, 2) != 0;
      flush      = $urandom_range(0, 15) == 0;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
